// File: rtl/rf_wb_unit.sv
// Register-file writeback unit: round-robin ALU/LSU arbitration, registered write port,
// per-register pending counters. Optional forwarding port under WB_BYPASS_EN.
module rf_wb_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic [ADDR_WIDTH-1:0]    iss_rd,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     rf_wen,
    output logic [ADDR_WIDTH-1:0]    rf_rd,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
`ifdef WB_BYPASS_EN
    output logic                     byp_valid,
    output logic [ADDR_WIDTH-1:0]    byp_rd,
    output logic [DATA_WIDTH-1:0]    byp_data,
`endif
    output logic [2**ADDR_WIDTH-1:0] busy
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic                  r_last_lsu;
    logic                  w_gnt_alu;
    logic                  w_gnt_lsu;
    logic [ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  r_rf_wen;
    logic [ADDR_WIDTH-1:0] r_rf_rd;
    logic [DATA_WIDTH-1:0] r_rf_wdata;
    logic                  w_iss_acc;
    logic [1:0]            w_cnt [NREG];

    // On a tie the source that did not win last time is granted.
    assign w_gnt_lsu  = lsu_valid && (!alu_valid || !r_last_lsu);
    assign w_gnt_alu  = alu_valid && (!lsu_valid ||  r_last_lsu);
    assign alu_ready  = w_gnt_alu;
    assign lsu_ready  = w_gnt_lsu;
    assign w_sel_rd   = w_gnt_lsu ? lsu_rd   : alu_rd;
    assign w_sel_data = w_gnt_lsu ? lsu_data : alu_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_lsu <= 1'b0;
        end else if (w_gnt_lsu) begin
            r_last_lsu <= 1'b1;
        end else if (w_gnt_alu) begin
            r_last_lsu <= 1'b0;
        end
    end

    // x0 writes are accepted but never raise the write enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_wen   <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
        end else if (w_gnt_alu || w_gnt_lsu) begin
            r_rf_wen   <= (w_sel_rd != '0);
            r_rf_rd    <= w_sel_rd;
            r_rf_wdata <= w_sel_data;
        end else begin
            r_rf_wen   <= 1'b0;
        end
    end

    assign rf_wen   = r_rf_wen;
    assign rf_rd    = r_rf_rd;
    assign rf_wdata = r_rf_wdata;

`ifdef WB_BYPASS_EN
    assign byp_valid = r_rf_wen;
    assign byp_rd    = r_rf_rd;
    assign byp_data  = r_rf_wdata;
`endif

    // A commit this cycle frees a slot even when the destination counter is full.
    assign iss_ready = (w_cnt[iss_rd] != 2'd3) || (r_rf_wen && (r_rf_rd == iss_rd));
    assign w_iss_acc = iss_valid && iss_ready && (iss_rd != '0);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_cnt[gi] = 2'd0;
            end else begin : g_cnt
                logic [1:0] r_cnt;
                logic       w_inc;
                logic       w_dec;

                assign w_inc = w_iss_acc && (iss_rd == ADDR_WIDTH'(gi));
                assign w_dec = r_rf_wen && (r_rf_rd == ADDR_WIDTH'(gi));

                // Unmatched writebacks hold the count at zero instead of wrapping.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_cnt <= 2'd0;
                    end else if (w_inc && !w_dec) begin
                        r_cnt <= r_cnt + 2'd1;
                    end else if (w_dec && !w_inc && (r_cnt != 2'd0)) begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end

                assign w_cnt[gi] = r_cnt;
            end
            assign busy[gi] = (w_cnt[gi] != 2'd0);
        end
    endgenerate

endmodule

// File: tb/tb_rf_wb_unit.sv
// Self-checking bench for rf_wb_unit: per-cycle model comparison plus directed literal checks.
// Build with +define+WB_BYPASS_EN to also exercise the forwarding port.
module tb_rf_wb_unit;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iss_valid;
    logic          iss_ready;
    logic [AW-1:0] iss_rd;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          rf_wen;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_wdata;
    logic [NREG-1:0] busy;
`ifdef WB_BYPASS_EN
    logic          byp_valid;
    logic [AW-1:0] byp_rd;
    logic [DW-1:0] byp_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_wen    (rf_wen),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
`ifdef WB_BYPASS_EN
        .byp_valid (byp_valid),
        .byp_rd    (byp_rd),
        .byp_data  (byp_data),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who won last, what is committing, outstanding writes per register.
    bit            m_ok = 0;
    bit            m_last_lsu;
    bit            m_wen;
    int            m_rd;
    logic [DW-1:0] m_wd;
    int            m_cnt [NREG];

    // 0 = nobody, 1 = ALU, 2 = LSU
    function automatic int m_winner();
        if (alu_valid && lsu_valid) return m_last_lsu ? 1 : 2;
        if (alu_valid) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    function automatic bit m_iss_ready();
        return (m_cnt[int'(iss_rd)] < 3) || (m_wen && m_rd == int'(iss_rd));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok = 1;
            m_last_lsu = 0;
            m_wen = 0;
            m_rd = 0;
            m_wd = '0;
            for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        end else if (m_ok) begin
            int  w;
            bit  ir;
            w  = m_winner();
            ir = m_iss_ready();
            for (int i = 1; i < NREG; i++) begin
                bit inc, dec;
                inc = iss_valid && ir && int'(iss_rd) == i;
                dec = m_wen && m_rd == i;
                if (inc && !dec) m_cnt[i] = m_cnt[i] + 1;
                else if (dec && !inc && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            end
            if (w == 0) begin
                m_wen = 0;
            end else begin
                m_rd       = (w == 1) ? int'(alu_rd) : int'(lsu_rd);
                m_wd       = (w == 1) ? alu_data : lsu_data;
                m_wen      = (m_rd != 0);
                m_last_lsu = (w == 2);
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok && rst_n) begin
            logic [NREG-1:0] eb;
            int w;
            w = m_winner();
            for (int i = 0; i < NREG; i++) eb[i] = (m_cnt[i] != 0);
            chk("m_alu_ready", 64'(alu_ready), 64'(w == 1));
            chk("m_lsu_ready", 64'(lsu_ready), 64'(w == 2));
            chk("m_iss_ready", 64'(iss_ready), 64'(m_iss_ready()));
            chk("m_rf_wen",    64'(rf_wen),    64'(m_wen));
            chk("m_rf_rd",     64'(rf_rd),     64'(m_rd));
            chk("m_rf_wdata",  64'(rf_wdata),  64'(m_wd));
            chk("m_busy",      64'(busy),      64'(eb));
`ifdef WB_BYPASS_EN
            chk("m_byp_valid", 64'(byp_valid), 64'(m_wen));
            chk("m_byp_rd",    64'(byp_rd),    64'(m_rd));
            chk("m_byp_data",  64'(byp_data),  64'(m_wd));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed mixed traffic: {alu_v, lsu_v, iss_v, iss_rd, alu_rd, lsu_rd}
    typedef struct { bit av; bit lv; bit iv; int ird; int ard; int lrd; } vec_t;
    vec_t vecs [6] = '{
        '{1, 0, 1, 4, 4, 0},
        '{0, 1, 1, 4, 0, 4},
        '{1, 1, 1, 6, 4, 6},
        '{1, 1, 0, 0, 6, 4},
        '{0, 0, 1, 0, 0, 0},
        '{1, 0, 0, 0, 6, 0}
    };

    initial begin
        rst_n = 1'b0; iss_valid = 0; iss_rd = '0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        step(); step();
        rst_n = 1'b1;
        chk("reset_wen",   64'(rf_wen),   64'd0);
        chk("reset_rd",    64'(rf_rd),    64'd0);
        chk("reset_wdata", 64'(rf_wdata), 64'd0);
        chk("reset_busy",  64'(busy),     64'd0);

        // ALU alone
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        @(negedge clk); chk("alu_only_ready", 64'(alu_ready), 64'd1);
        step(); alu_valid = 0;
        chk("alu_only_wen", 64'(rf_wen), 64'd1);
        chk("alu_only_rd", 64'(rf_rd), 64'd5);
        chk("alu_only_wdata", 64'(rf_wdata), 64'h1234);
        step();
        chk("alu_only_wen_off", 64'(rf_wen), 64'd0);

        // Contention: LSU first, then alternate
        alu_valid = 1; alu_rd = 1; alu_data = 32'hA1;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cont_lsu_gnt", 64'(lsu_ready), 64'((k % 2) == 0));
            chk("cont_alu_gnt", 64'(alu_ready), 64'((k % 2) == 1));
            step();
            chk("cont_rf_rd", 64'(rf_rd), 64'(((k % 2) == 0) ? 2 : 1));
        end
        alu_valid = 0; lsu_valid = 0;

        // x0 write dropped
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFF_FFFF;
        @(negedge clk); chk("x0_ready", 64'(lsu_ready), 64'd1);
        step(); lsu_valid = 0;
        @(negedge clk); chk("x0_wen", 64'(rf_wen), 64'd0);

        // Scoreboard saturation on x7
        iss_valid = 1; iss_rd = 7;
        step(); step(); step();
        @(negedge clk);
        chk("sb_busy7", 64'(busy[7]), 64'd1);
        chk("sb_full", 64'(iss_ready), 64'd0);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        step(); alu_valid = 0;
        @(negedge clk); chk("sb_commit_frees", 64'(iss_ready), 64'd1);
        step(); iss_valid = 0;
        @(negedge clk);
        chk("sb_still_full", 64'(iss_ready), 64'd0);
        alu_valid = 1;
        step(); step(); step();
        alu_valid = 0;
        step(); step();
        chk("sb_drained", 64'(busy), 64'd0);

        // Mixed traffic
        for (int v = 0; v < 6; v++) begin
            alu_valid = vecs[v].av; lsu_valid = vecs[v].lv; iss_valid = vecs[v].iv;
            iss_rd = AW'(vecs[v].ird); alu_rd = AW'(vecs[v].ard); lsu_rd = AW'(vecs[v].lrd);
            alu_data = 32'hC000 + v; lsu_data = 32'hD000 + v;
            step();
        end
        alu_valid = 0; lsu_valid = 0; iss_valid = 0;
        step(); step();

`ifdef WB_BYPASS_EN
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'hABCD;
        step(); lsu_valid = 0;
        @(negedge clk);
        chk("byp_wen", 64'(rf_wen), 64'd1);
        chk("byp_valid", 64'(byp_valid), 64'd1);
        chk("byp_rd", 64'(byp_rd), 64'd9);
        chk("byp_data", 64'(byp_data), 64'hABCD);
        step();
`endif

        // Reset mid-flight
        iss_valid = 1; iss_rd = 3;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        step();
        iss_valid = 0; alu_valid = 0;
        chk("mid_wen_before", 64'(rf_wen), 64'd1);
        chk("mid_busy_before", 64'(busy[3]), 64'd1);
        rst_n = 0;
        step();
        chk("mid_rst_wen", 64'(rf_wen), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        rst_n = 1;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
